// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding four byte requesters into one UART transmitter
// Holds the grant for a whole frame and abandons it after a watchdog timeout.
module uart_tx_arbiter #(
    parameter int frequency = 50_000_000,
    parameter int BAUD      = 9600
) (
    input  logic        clk_tx,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [1:0]  active_id,
    output logic        busy,
    output logic        err_timeout
);

    localparam int baud_clk = frequency / BAUD;
    localparam int TIMEOUT  = 12 * baud_clk;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        WAIT_DONE
    } state_t;

    state_t      state;
    logic [1:0]  rr_ptr;
    logic [15:0] watchdog;
    logic        holdoff;

    logic        found;
    logic [1:0]  win;
    logic [1:0]  idx;

    always_comb begin
        found = 1'b0;
        win   = rr_ptr;
        idx   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk_tx) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 2'd0;
            watchdog    <= 16'd0;
            holdoff     <= 1'b0;
            tx_data     <= 8'd0;
            tx_start    <= 1'b0;
            gnt         <= 4'd0;
            ack         <= 4'd0;
            active_id   <= 2'd0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            ack      <= 4'd0;
            case (state)
                IDLE: begin
                    // holdoff spends one IDLE cycle after every frame before re-arbitrating
                    holdoff <= 1'b0;
                    if (!holdoff && found && !tx_busy) begin
                        state     <= WAIT_DONE;
                        tx_data   <= req_data[{win, 3'b000} +: 8];
                        tx_start  <= 1'b1;
                        ack       <= 4'b0001 << win;
                        gnt       <= 4'b0001 << win;
                        active_id <= win;
                        busy      <= 1'b1;
                        watchdog  <= 16'd0;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done || watchdog == WD_LAST) begin
                        if (!tx_done) begin
                            err_timeout <= 1'b1;
                        end
                        state    <= IDLE;
                        gnt      <= 4'd0;
                        busy     <= 1'b0;
                        rr_ptr   <= active_id + 2'd1;
                        watchdog <= 16'd0;
                        holdoff  <= 1'b1;
                    end else if (!tx_start) begin
                        // the launch cycle itself is watchdog count 0
                        watchdog <= watchdog + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a round-robin reference model
module tb_uart_tx_arbiter;

    localparam int FREQ = 96_000;
    localparam int BAUD_R = 9600;
    localparam int TOUT = 12 * (FREQ / BAUD_R);

    logic        clk_tx = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [1:0]  active_id;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int ptr = 0;
    int cur_win = 0;
    logic [7:0] cur_byte = 8'd0;

    uart_tx_arbiter #(.frequency(FREQ), .BAUD(BAUD_R)) dut (
        .clk_tx(clk_tx), .rst(rst), .req(req), .req_data(req_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_data(tx_data),
        .tx_start(tx_start), .gnt(gnt), .ack(ack), .active_id(active_id),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk_tx = ~clk_tx;

    initial begin
        #500_000;
        $display("FAIL sim_timeout observed=no_finish expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic step;
        @(posedge clk_tx);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first requester at or above the pointer, modulo 4.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic launch(input string tag, input logic [3:0] r, input logic [31:0] d);
        logic [3:0] oh;
        logic [31:0] sh;
        int w;
        w = rr_pick(r, ptr);
        oh = 4'd0;
        oh[w] = 1'b1;
        sh = d >> (8 * w);
        req = r;
        req_data = d;
        step;
        check({tag, "_start"}, {31'd0, tx_start}, 32'd1);
        check({tag, "_gnt"}, {28'd0, gnt}, {28'd0, oh});
        check({tag, "_ack"}, {28'd0, ack}, {28'd0, oh});
        check({tag, "_id"}, {30'd0, active_id}, w);
        check({tag, "_data"}, {24'd0, tx_data}, {24'd0, sh[7:0]});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cur_win = w;
        cur_byte = sh[7:0];
    endtask

    task automatic finish_frame(input string tag, input int delay, input bit scramble);
        logic [3:0] oh;
        oh = 4'd0;
        oh[cur_win] = 1'b1;
        for (int i = 0; i < delay; i++) begin
            if (scramble) begin
                req = 4'($urandom);
                req_data = $urandom;
                tx_busy = 1'($urandom);
            end
            step;
            check({tag, "_hold_gnt"}, {28'd0, gnt}, {28'd0, oh});
            check({tag, "_hold_data"}, {24'd0, tx_data}, {24'd0, cur_byte});
            check({tag, "_pulse"}, {27'd0, tx_start, ack}, 32'd0);
            check({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
        end
        req = 4'hF;
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step;
        tx_done = 1'b0;
        check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_gnt"}, {28'd0, gnt}, 32'd0);
        check({tag, "_idle_data"}, {24'd0, tx_data}, {24'd0, cur_byte});
        ptr = (cur_win + 1) % 4;
        step;
        check({tag, "_spacing"}, {31'd0, tx_start}, 32'd0);
        req = 4'd0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        rst = 1'b0;
        ptr = 0;
    endtask

    initial begin
        logic [3:0] r;
        logic [31:0] d;
        int nb;

        // Reset state, with requests present while rst is high
        rst = 1'b1;
        req = 4'hF;
        req_data = $urandom;
        step;
        step;
        check("rst_start_ack", {27'd0, tx_start, ack}, 32'd0);
        check("rst_gnt", {28'd0, gnt}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_id_busy_err", {29'd0, active_id, busy, err_timeout}, 32'd0);
        rst = 1'b0;
        req = 4'd0;
        step;
        step;
        check("idle_noreq", {23'd0, gnt, ack, tx_start}, 32'd0);

        // Single request, normal completion
        launch("single", 4'b0100, 32'h12A5_3456);
        check("single_a5", {24'd0, tx_data}, 32'hA5);
        check("single_id2", {30'd0, active_id}, 32'd2);
        finish_frame("single", 2, 1'b0);

        // Full-load rotation from a fresh pointer
        do_reset;
        for (int i = 0; i < 5; i++) begin
            launch("rr", 4'b1111, $urandom);
            check("rr_order", {30'd0, active_id}, i % 4);
            finish_frame("rr", 1, 1'b0);
        end

        // Transmitter busy blocks arbitration
        tx_busy = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step;
            check("txbusy_block", {27'd0, tx_start, gnt}, 32'd0);
        end
        tx_busy = 1'b0;
        launch("txbusy_release", 4'b0001, $urandom);
        finish_frame("txbusy_release", 3, 1'b0);

        // Request dropped before arbitration, and tx_done in IDLE
        tx_busy = 1'b1;
        req = 4'b1000;
        step;
        req = 4'd0;
        tx_busy = 1'b0;
        tx_done = 1'b1;
        step;
        tx_done = 1'b0;
        check("drop_no_start", {27'd0, tx_start, gnt}, 32'd0);
        check("done_in_idle", {31'd0, busy}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 20; n++) begin
            r = 4'($urandom);
            if (r == 4'd0) r = 4'd1;
            d = $urandom;
            nb = $urandom_range(3, 0);
            tx_busy = 1'b1;
            req = r;
            for (int i = 0; i < nb; i++) begin
                step;
                check("rand_busy_block", {31'd0, tx_start}, 32'd0);
            end
            tx_busy = 1'b0;
            launch("rand", r, d);
            finish_frame("rand", $urandom_range(6, 0), 1'b1);
        end

        // Watchdog timeout
        launch("tmo", 4'b0010, $urandom);
        for (int k = 1; k <= TOUT; k++) begin
            step;
            check("tmo_wait", {30'd0, busy, err_timeout}, 32'd2);
        end
        step;
        check("tmo_err", {31'd0, err_timeout}, 32'd1);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_gnt", {28'd0, gnt}, 32'd0);
        ptr = (cur_win + 1) % 4;
        step;
        launch("tmo_after", 4'b0110, $urandom);
        finish_frame("tmo_after", 2, 1'b0);
        check("tmo_sticky", {31'd0, err_timeout}, 32'd1);

        // tx_done coinciding with the timeout point
        do_reset;
        check("err_cleared", {31'd0, err_timeout}, 32'd0);
        launch("simul", 4'b1001, $urandom);
        for (int k = 1; k <= TOUT; k++) step;
        tx_done = 1'b1;
        step;
        tx_done = 1'b0;
        check("simul_err", {31'd0, err_timeout}, 32'd0);
        check("simul_busy", {31'd0, busy}, 32'd0);
        ptr = (cur_win + 1) % 4;
        step;

        // Reset in the middle of a frame
        launch("pre_rst", 4'b0100, $urandom);
        finish_frame("pre_rst", 1, 1'b0);
        launch("mid", 4'b0010, $urandom);
        step;
        step;
        rst = 1'b1;
        step;
        check("midrst_gnt", {28'd0, gnt}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ptr", {30'd0, dut.rr_ptr}, 32'd0);
        check("midrst_data_id", {22'd0, tx_data, active_id}, 32'd0);
        rst = 1'b0;
        ptr = 0;
        launch("midrst_next", 4'b1010, $urandom);
        check("midrst_winner1", {30'd0, active_id}, 32'd1);
        finish_frame("midrst_next", 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
